// File: rtl/ascon_ctrl_pkg.sv
// Shared types for the digit-serial ASCON permutation controller: the FSM state
// enum, the per-phase select/enable patterns and the round-constant function.
package ascon_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADDC,
    ST_SBOX,
    ST_X0,
    ST_X1,
    ST_X2,
    ST_X3A,
    ST_X3B,
    ST_X4,
    ST_FIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_ADDC = 2'b01;
  localparam logic [1:0] SEL_SBOX = 2'b11;
  localparam logic [1:0] SEL_LIN  = 2'b10;

  // Word enables are ordered bit4=x0 .. bit0=x4.
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_X0  = 5'b10000;
  localparam logic [4:0] EN_X1  = 5'b11000;
  localparam logic [4:0] EN_X2  = 5'b01100;
  localparam logic [4:0] EN_X3  = 5'b00110;
  localparam logic [4:0] EN_X4  = 5'b00011;
  localparam logic [4:0] EN_FIN = 5'b00001;

  localparam logic [2:0] TS_X0  = 3'b000;
  localparam logic [2:0] TS_X1  = 3'b001;
  localparam logic [2:0] TS_X2  = 3'b011;
  localparam logic [2:0] TS_X3A = 3'b010;
  localparam logic [2:0] TS_X3B = 3'b110;
  localparam logic [2:0] TS_X4  = 3'b111;
  localparam logic [2:0] TS_FIN = 3'b101;

  // ASCON round constant for absolute round index i: high nibble 0xF-i, low nibble i.
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

endpackage

// File: rtl/ascon_beat_counter.sv
// Up-counter with synchronous clear (priority over increment) and a compare
// against a caller-supplied terminal value; used for both beats and rounds.
module ascon_beat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         is_last
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == last);

endmodule

// File: rtl/ascon_perm_ctrl_ds.sv
// Digit-serial ASCON permutation controller: phase FSM plus Moore output decode.
// Optional stall input enabled by defining ASCON_PERM_STALL_EN.
module ascon_perm_ctrl_ds
  import ascon_ctrl_pkg::*;
#(
  parameter int DW         = 1,
  parameter int ROUNDS_MAX = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_permutation,
  input  logic [3:0]    rounds,
`ifdef ASCON_PERM_STALL_EN
  input  logic          stall,
`endif
  output logic [1:0]    state_sel,
  output logic [4:0]    enable,
  output logic          temp_enable,
  output logic [2:0]    temp_sel,
  output logic          const_add,
  output logic [DW-1:0] const_slice,
  output logic          busy,
  output logic          done
);

  localparam int BEATS = 64 / DW;
  localparam int CB    = 8 / DW;
  localparam int BW    = $clog2(BEATS);

  state_t        state, state_nxt;
  logic [3:0]    r_lat;
  logic [BW-1:0] beat_cnt, phase_last;
  logic          beat_last;
  logic [3:0]    rcnt;
  logic          rnd_last;
  logic          run_state;
  logic          hold;
  logic          advance;
  logic          phase_end;
  logic          accept;
  logic [3:0]    rc_idx;
  logic [7:0]    rc_bits;

  assign run_state = (state != ST_IDLE) && (state != ST_DONE);
`ifdef ASCON_PERM_STALL_EN
  assign hold = stall && run_state;
`else
  assign hold = 1'b0;
`endif
  assign advance   = run_state && !hold;
  assign phase_end = advance && beat_last;
  assign accept    = (state == ST_IDLE) && start_permutation;

  always_comb begin
    phase_last = BW'(BEATS - 1);
    case (state)
      ST_LOAD, ST_X3A: phase_last = BW'(BEATS - CB - 1);
      ST_ADDC, ST_X3B: phase_last = BW'(CB - 1);
      ST_IDLE, ST_DONE: phase_last = '0;
      default: phase_last = BW'(BEATS - 1);
    endcase
  end

  ascon_beat_counter #(.W(BW)) u_beat (
    .clk     (clk),
    .rst     (rst),
    .clear   (phase_end),
    .inc     (advance),
    .last    (phase_last),
    .count   (beat_cnt),
    .is_last (beat_last)
  );

  ascon_beat_counter #(.W(4)) u_round (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_IDLE),
    .inc     ((state == ST_FIN) && phase_end && !rnd_last),
    .last    (r_lat - 4'd1),
    .count   (rcnt),
    .is_last (rnd_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      r_lat <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_lat <= ((rounds == 4'd0) || (int'(rounds) > ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds;
      end
    end
  end

  // X3B pre-loads the constant of the following round, ADDC that of round 0.
  assign rc_idx  = 4'(ROUNDS_MAX) - r_lat + ((state == ST_X3B) ? rcnt + 4'd1 : rcnt);
  assign rc_bits = rc(rc_idx);

  always_comb begin
    state_nxt   = state;
    state_sel   = SEL_LOAD;
    enable      = '0;
    temp_enable = 1'b0;
    temp_sel    = '0;
    const_add   = 1'b0;
    const_slice = '0;
    busy        = run_state;
    done        = 1'b0;
    case (state)
      ST_IDLE: if (start_permutation) state_nxt = ST_LOAD;
      ST_LOAD: begin
        enable = EN_ALL;
        if (phase_end) state_nxt = ST_ADDC;
      end
      ST_ADDC: begin
        state_sel = SEL_ADDC; enable = EN_ALL; const_add = 1'b1;
        if (phase_end) state_nxt = ST_SBOX;
      end
      ST_SBOX: begin
        state_sel = SEL_SBOX; enable = EN_ALL;
        if (phase_end) state_nxt = ST_X0;
      end
      ST_X0: begin
        state_sel = SEL_LIN; enable = EN_X0; temp_sel = TS_X0; temp_enable = 1'b1;
        if (phase_end) state_nxt = ST_X1;
      end
      ST_X1: begin
        state_sel = SEL_LIN; enable = EN_X1; temp_sel = TS_X1; temp_enable = 1'b1;
        if (phase_end) state_nxt = ST_X2;
      end
      ST_X2: begin
        state_sel = SEL_LIN; enable = EN_X2; temp_sel = TS_X2; temp_enable = 1'b1;
        if (phase_end) state_nxt = ST_X3A;
      end
      ST_X3A: begin
        state_sel = SEL_LIN; enable = EN_X3; temp_sel = TS_X3A; temp_enable = 1'b1;
        if (phase_end) state_nxt = ST_X3B;
      end
      ST_X3B: begin
        state_sel = SEL_LIN; enable = EN_X3; temp_sel = TS_X3B; temp_enable = 1'b1;
        const_add = !rnd_last;
        if (phase_end) state_nxt = ST_X4;
      end
      ST_X4: begin
        state_sel = SEL_LIN; enable = EN_X4; temp_sel = TS_X4; temp_enable = 1'b1;
        if (phase_end) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_sel = SEL_LIN; enable = EN_FIN; temp_sel = TS_FIN; temp_enable = 1'b1;
        if (phase_end) state_nxt = rnd_last ? ST_DONE : ST_SBOX;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (hold) begin
      enable      = '0;
      temp_enable = 1'b0;
      const_add   = 1'b0;
    end
    if (const_add) const_slice = DW'(rc_bits >> (int'(beat_cnt) * DW));
  end

endmodule

// File: tb/tb_ascon_perm_ctrl_ds.sv
// Self-checking bench for ascon_perm_ctrl_ds at DW=1/4/8; per-cycle traces are
// compared against a phase-table model built from plain arithmetic.
module tb_ascon_perm_ctrl_ds;

  typedef logic [21:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v    [3];
  logic       start_v  [3];
  logic [3:0] rounds_v [3];
`ifdef ASCON_PERM_STALL_EN
  logic       stall_v  [3];
`endif
  vec_t obs [3];

  vec_t exp_q[$];
  vec_t act_q[$];
  int   checks = 0;
  int   errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GDW = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    logic [1:0]     ss;
    logic [4:0]     en;
    logic           te;
    logic [2:0]     ts;
    logic           ca;
    logic [GDW-1:0] cs;
    logic           bsy;
    logic           dn;
    ascon_perm_ctrl_ds #(.DW(GDW), .ROUNDS_MAX(12)) dut (
      .clk               (clk),
      .rst               (rst_v[g]),
      .start_permutation (start_v[g]),
      .rounds            (rounds_v[g]),
`ifdef ASCON_PERM_STALL_EN
      .stall             (stall_v[g]),
`endif
      .state_sel         (ss),
      .enable            (en),
      .temp_enable       (te),
      .temp_sel          (ts),
      .const_add         (ca),
      .const_slice       (cs),
      .busy              (bsy),
      .done              (dn)
    );
    assign obs[g] = {bsy, dn, ss, en, te, ts, ca, 8'(cs)};
  end

  function automatic vec_t mk(input bit b, input bit d, input logic [1:0] ss, input logic [4:0] en,
                              input bit te, input logic [2:0] ts, input bit ca, input int cs);
    return {b, d, ss, en, te, ts, ca, 8'(cs)};
  endfunction

  function automatic int rc_model(input int rr, input int r);
    int i;
    i = 12 - rr + r;
    return (((15 - i) << 4) | i) & 255;
  endfunction

  // Expected trace from the first cycle after accept through the trailing IDLE cycle.
  function automatic void build_expected(input int dw, input int r_req);
    int rr, beats, cb, mask;
    rr    = (r_req == 0 || r_req > 12) ? 12 : r_req;
    beats = 64 / dw;
    cb    = 8 / dw;
    mask  = (1 << dw) - 1;
    exp_q.delete();
    repeat (beats - cb) exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 5'b11111, 1'b0, 3'b000, 1'b0, 0));
    for (int b = 0; b < cb; b++)
      exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 5'b11111, 1'b0, 3'b000, 1'b1, (rc_model(rr, 0) >> (b * dw)) & mask));
    for (int r = 0; r < rr; r++) begin
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b11, 5'b11111, 1'b0, 3'b000, 1'b0, 0));
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b10000, 1'b1, 3'b000, 1'b0, 0));
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b11000, 1'b1, 3'b001, 1'b0, 0));
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b01100, 1'b1, 3'b011, 1'b0, 0));
      repeat (beats - cb) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b00110, 1'b1, 3'b010, 1'b0, 0));
      for (int b = 0; b < cb; b++) begin
        if (r == rr - 1)
          exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b00110, 1'b1, 3'b110, 1'b0, 0));
        else
          exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b00110, 1'b1, 3'b110, 1'b1,
                             (rc_model(rr, r + 1) >> (b * dw)) & mask));
      end
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b00011, 1'b1, 3'b111, 1'b0, 0));
      repeat (beats) exp_q.push_back(mk(1'b1, 1'b0, 2'b10, 5'b00001, 1'b1, 3'b101, 1'b0, 0));
    end
    exp_q.push_back(mk(1'b0, 1'b1, 2'b00, 5'b00000, 1'b0, 3'b000, 1'b0, 0));
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 5'b00000, 1'b0, 3'b000, 1'b0, 0));
  endfunction

  function automatic int trace_diff_at();
    if (act_q.size() < exp_q.size()) return act_q.size();
    foreach (exp_q[k]) if (act_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  function automatic int find_done();
    foreach (act_q[k]) if (act_q[k][20] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_busy();
    int n = 0;
    foreach (act_q[k]) if (act_q[k][21] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_const();
    int n = 0;
    foreach (act_q[k]) if (act_q[k][8] === 1'b1) n++;
    return n;
  endfunction

  task automatic launch(input int idx, input int r);
    @(negedge clk);
    rounds_v[idx] = 4'(r);
    start_v[idx]  = 1'b1;
  endtask

  task automatic capture(input int idx, input int n, input bit release_start, input int stall_at, input int stall_len);
    act_q.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
`ifdef ASCON_PERM_STALL_EN
      stall_v[idx] = (stall_at >= 0) && (k >= stall_at) && (k < stall_at + stall_len);
`endif
      #1;
      act_q.push_back(obs[idx]);
      if (k == 0 && release_start) start_v[idx] = 1'b0;
    end
`ifdef ASCON_PERM_STALL_EN
    stall_v[idx] = 1'b0;
`endif
  endtask

  task automatic report_trace(input string name);
    int d;
    d = trace_diff_at();
    checks++;
    if (d != -1) begin
      errors++;
      if (d < act_q.size())
        $display("[TB] FAIL %s cycle %0d got %h want %h", name, d, act_q[d], exp_q[d]);
      else
        $display("[TB] FAIL %s trace short got %0d want %0d cycles", name, act_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; rounds_v[i] = 4'd0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d got %h want 0", i, obs[i]);
      end
    end
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
  endtask

  task automatic test_dw1_full();
    logic [7:0] acc;
    int n;
    build_expected(1, 12);
    launch(0, 12);
    capture(0, exp_q.size(), 1'b1, -1, 0);
    report_trace("dw1_trace");
    checks++;
    if (count_busy() != 5440) begin
      errors++;
      $display("[TB] FAIL dw1_busy_cycles got %0d want 5440", count_busy());
    end
    checks++;
    if (find_done() != 5440) begin
      errors++;
      $display("[TB] FAIL dw1_done_cycle got %0d want 5440", find_done());
    end
    acc = '0;
    n = 0;
    foreach (act_q[k]) if (act_q[k][8] === 1'b1 && n < 8) begin
      acc[n] = act_q[k][0];
      n++;
    end
    checks++;
    if (acc !== 8'hF0 || n != 8) begin
      errors++;
      $display("[TB] FAIL dw1_first_rc got %h (%0d beats) want f0", acc, n);
    end
  endtask

  task automatic test_dw8();
    int seen;
    logic [7:0] s0, s1;
    build_expected(8, 6);
    launch(2, 6);
    capture(2, exp_q.size(), 1'b1, -1, 0);
    report_trace("dw8_trace");
    seen = 0; s0 = '0; s1 = '0;
    foreach (act_q[k]) if (act_q[k][8] === 1'b1) begin
      if (seen == 0) s0 = act_q[k][7:0];
      if (seen == 1) s1 = act_q[k][7:0];
      seen++;
    end
    checks++;
    if (s0 !== 8'h96) begin
      errors++;
      $display("[TB] FAIL dw8_addc_slice got %h want 96", s0);
    end
    checks++;
    if (s1 !== 8'h87) begin
      errors++;
      $display("[TB] FAIL dw8_x3b_slice got %h want 87", s1);
    end
    checks++;
    if (find_done() != 344) begin
      errors++;
      $display("[TB] FAIL dw8_done_cycle got %0d want 344", find_done());
    end
  endtask

  task automatic test_start_held();
    build_expected(8, 2);
    launch(2, 2);
    capture(2, exp_q.size() + 1, 1'b0, -1, 0);
    start_v[2] = 1'b0;
    report_trace("held_trace");
    checks++;
    if (act_q[exp_q.size()] !== mk(1'b1, 1'b0, 2'b00, 5'b11111, 1'b0, 3'b000, 1'b0, 0)) begin
      errors++;
      $display("[TB] FAIL held_restart got %h want LOAD beat", act_q[exp_q.size()]);
    end
    rst_v[2] = 1'b0;
    @(negedge clk);
    rst_v[2] = 1'b1;
  endtask

  task automatic test_rounds_clamp();
    int vals[2] = '{0, 15};
    foreach (vals[j]) begin
      build_expected(8, vals[j]);
      launch(2, vals[j]);
      capture(2, exp_q.size(), 1'b1, -1, 0);
      report_trace("clamp_trace");
      checks++;
      if (find_done() != 680) begin
        errors++;
        $display("[TB] FAIL clamp_done rounds=%0d got %0d want 680", vals[j], find_done());
      end
    end
    build_expected(8, 1);
    launch(2, 1);
    capture(2, exp_q.size(), 1'b1, -1, 0);
    report_trace("one_round_trace");
    checks++;
    if (count_const() != 1 || find_done() != 64) begin
      errors++;
      $display("[TB] FAIL one_round const_beats=%0d done=%0d want 1 and 64", count_const(), find_done());
    end
  endtask

  task automatic test_reset_mid();
    int r;
    r = $urandom_range(1, 12);
    launch(1, r);
    capture(1, 70, 1'b1, -1, 0);
    checks++;
    if (act_q[69] !== mk(1'b1, 1'b0, 2'b10, 5'b01100, 1'b1, 3'b011, 1'b0, 0)) begin
      errors++;
      $display("[TB] FAIL midrst_in_x2 got %h want X2 beat", act_q[69]);
    end
    rst_v[1] = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs[1] !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got %h want 0", obs[1]);
    end
    rst_v[1] = 1'b1;
    capture(1, 6, 1'b0, -1, 0);
    checks++;
    if (find_done() != -1 || count_busy() != 0) begin
      errors++;
      $display("[TB] FAIL midrst_quiet done_at=%0d busy=%0d want -1 and 0", find_done(), count_busy());
    end
    r = $urandom_range(1, 12);
    build_expected(4, r);
    launch(1, r);
    capture(1, exp_q.size(), 1'b1, -1, 0);
    report_trace("midrst_rerun");
  endtask

  task automatic test_random();
    int idx, r, dw;
    for (int it = 0; it < 4; it++) begin
      idx = $urandom_range(0, 2);
      r   = $urandom_range(0, 15);
      dw  = (idx == 0) ? 1 : ((idx == 1) ? 4 : 8);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      build_expected(dw, r);
      launch(idx, r);
      capture(idx, exp_q.size(), 1'b1, -1, 0);
      report_trace("random_trace");
    end
  endtask

`ifdef ASCON_PERM_STALL_EN
  task automatic test_stall();
    vec_t frozen;
    int zero_en;
    build_expected(8, 2);
    frozen = exp_q[11];
    frozen[17:13] = '0;
    frozen[12]    = 1'b0;
    frozen[8:0]   = '0;
    repeat (5) exp_q.insert(11, frozen);
    launch(2, 2);
    capture(2, exp_q.size(), 1'b1, 11, 5);
    report_trace("stall_trace");
    zero_en = 0;
    for (int k = 11; k < 16; k++) if (act_q[k][17:13] === 5'b0) zero_en++;
    checks++;
    if (zero_en != 5 || find_done() != 125) begin
      errors++;
      $display("[TB] FAIL stall_effect zero_enable=%0d done=%0d want 5 and 125", zero_en, find_done());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; rounds_v[i] = 4'd0;
`ifdef ASCON_PERM_STALL_EN
      stall_v[i] = 1'b0;
`endif
    end
    test_reset();
    test_dw1_full();
    test_dw8();
    test_start_held();
    test_rounds_clamp();
    test_reset_mid();
    test_random();
`ifdef ASCON_PERM_STALL_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
